// File: rtl/pll_96_supervisor.sv
// Reset sequencer for a 96 MHz PLL clocked from the free-running 125 MHz refclk.
// Optional status counters are enabled by defining PLL_96_SUPERVISOR_STATUS_EN.
module pll_96_supervisor #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 125000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRY     = 8
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  input  logic       force_reset,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [7:0] lock_loss_cnt,
  output logic [7:0] retry_cnt
);

  localparam int unsigned MaxA   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MaxCnt = (MaxA > STABLE_CYCLES) ? MaxA : STABLE_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  typedef enum logic [2:0] {
    StRstPll,
    StWaitLock,
    StStable,
    StRun,
    StFail
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [7:0]        retry_q, retry_d;
  logic              lock_meta_q, lock_s_q;
  logic [8:0]        retry_inc;

  assign retry_inc = {1'b0, retry_q} + 9'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    unique case (state_q)
      StRstPll: begin
        if (cnt_q == CntW'(RST_CYCLES - 1)) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitLock: begin
        if (lock_s_q) begin
          state_d = StStable;
          cnt_d   = '0;
        end else if (cnt_q == CntW'(LOCK_TIMEOUT - 1)) begin
          cnt_d   = '0;
          retry_d = retry_inc[8] ? retry_q : retry_inc[7:0];
          state_d = (retry_inc == 9'(MAX_RETRY)) ? StFail : StRstPll;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStable: begin
        // A lock glitch restarts the lock wait but is not a timeout, so no retry charge.
        if (!lock_s_q) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == CntW'(STABLE_CYCLES - 1)) begin
          state_d = StRun;
          cnt_d   = '0;
          retry_d = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRun: begin
        if (!lock_s_q) begin
          state_d = StRstPll;
          cnt_d   = '0;
        end
      end
      StFail: begin
        state_d = StFail;
      end
      default: begin
        state_d = StRstPll;
        cnt_d   = '0;
      end
    endcase
    if (force_reset) begin
      state_d = StRstPll;
      cnt_d   = '0;
      retry_d = '0;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q     <= StRstPll;
      cnt_q       <= '0;
      retry_q     <= '0;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      lock_meta_q <= locked;
      lock_s_q    <= lock_meta_q;
    end
  end

  always_comb begin
    pll_rst = (state_q == StRstPll) || (state_q == StFail);
    sys_rst = (state_q != StRun);
    ready   = (state_q == StRun);
    fail    = (state_q == StFail);
  end

`ifdef PLL_96_SUPERVISOR_STATUS_EN
  logic [7:0] lock_loss_q, lock_loss_d;

  // State leaves RUN on any loss (with or without force_reset), so this fires once per event.
  always_comb begin
    lock_loss_d = lock_loss_q;
    if ((state_q == StRun) && !lock_s_q && (lock_loss_q != 8'hff)) begin
      lock_loss_d = lock_loss_q + 8'd1;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      lock_loss_q <= '0;
    end else begin
      lock_loss_q <= lock_loss_d;
    end
  end

  assign lock_loss_cnt = lock_loss_q;
  assign retry_cnt     = retry_q;
`else
  assign lock_loss_cnt = 8'd0;
  assign retry_cnt     = 8'd0;
`endif

endmodule

// File: tb/tb_pll_96_supervisor.sv
// Directed bench for pll_96_supervisor with short timing parameters.
// Counter expectations follow PLL_96_SUPERVISOR_STATUS_EN (zero when undefined).
module tb_pll_96_supervisor;

`ifdef PLL_96_SUPERVISOR_STATUS_EN
  localparam bit StatusEn = 1'b1;
`else
  localparam bit StatusEn = 1'b0;
`endif

  logic       refclk;
  logic       rst;
  logic       locked;
  logic       force_reset;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fail;
  logic [7:0] lock_loss_cnt;
  logic [7:0] retry_cnt;

  int n_total = 0;
  int n_bad   = 0;

  pll_96_supervisor #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (50),
    .STABLE_CYCLES(8),
    .MAX_RETRY    (2)
  ) u_dut (
    .refclk       (refclk),
    .rst          (rst),
    .locked       (locked),
    .force_reset  (force_reset),
    .pll_rst      (pll_rst),
    .sys_rst      (sys_rst),
    .ready        (ready),
    .fail         (fail),
    .lock_loss_cnt(lock_loss_cnt),
    .retry_cnt    (retry_cnt)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_cnt(input int v);
    return StatusEn ? v : 0;
  endfunction

  // Advance n rising edges and settle just after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!ready && n < 40) begin
      step(1);
      n++;
    end
    check_eq(tag, int'(ready), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    locked      = 1'b0;
    force_reset = 1'b0;
    step(3);
    check_eq("rst_pll_rst", int'(pll_rst), 1);
    check_eq("rst_sys_rst", int'(sys_rst), 1);
    check_eq("rst_ready", int'(ready), 0);
    check_eq("rst_fail", int'(fail), 0);
    check_eq("rst_loss", int'(lock_loss_cnt), 0);
    check_eq("rst_retry", int'(retry_cnt), 0);

    // Power-up with lock arriving after the reset pulse.
    rst = 1'b0;
    step(3);
    check_eq("pu_pulse_hi", int'(pll_rst), 1);
    step(1);
    check_eq("pu_pulse_lo", int'(pll_rst), 0);
    locked = 1'b1;
    step(10);
    check_eq("pu_not_ready_early", int'(ready), 0);
    step(1);
    check_eq("pu_ready", int'(ready), 1);
    check_eq("pu_sys_rst", int'(sys_rst), 0);

    // Lock loss in RUN.
    locked = 1'b0;
    step(2);
    check_eq("loss_ready_held", int'(ready), 1);
    step(1);
    check_eq("loss_ready", int'(ready), 0);
    check_eq("loss_sys_rst", int'(sys_rst), 1);
    check_eq("loss_pll_rst", int'(pll_rst), 1);
    check_eq("loss_cnt1", int'(lock_loss_cnt), exp_cnt(1));
    step(3);
    check_eq("loss_pulse_hi", int'(pll_rst), 1);
    step(1);
    check_eq("loss_pulse_lo", int'(pll_rst), 0);
    locked = 1'b1;
    wait_ready("loss_relock");
    check_eq("loss_relock_sys_rst", int'(sys_rst), 0);

    // force_reset coinciding with a lock drop in RUN counts as one loss.
    locked = 1'b0;
    step(2);
    check_eq("coinc_still_run", int'(ready), 1);
    force_reset = 1'b1;
    step(1);
    force_reset = 1'b0;
    check_eq("coinc_pll_rst", int'(pll_rst), 1);
    check_eq("coinc_ready", int'(ready), 0);
    check_eq("coinc_loss", int'(lock_loss_cnt), exp_cnt(2));
    check_eq("coinc_retry", int'(retry_cnt), 0);
    step(3);
    check_eq("coinc_pulse_hi", int'(pll_rst), 1);
    check_eq("coinc_loss_once", int'(lock_loss_cnt), exp_cnt(2));
    step(1);
    check_eq("coinc_pulse_lo", int'(pll_rst), 0);
    locked = 1'b1;
    wait_ready("coinc_relock");

    // 298 more losses: 300 total, saturating at 255.
    for (int i = 0; i < 298; i++) begin
      locked = 1'b0;
      step(3);
      locked = 1'b1;
      wait_ready("sat_relock");
    end
    check_eq("sat_loss", int'(lock_loss_cnt), exp_cnt(255));

    // Lock never arrives: two timeouts then FAIL. force_reset held during rst is ignored.
    rst         = 1'b1;
    locked      = 1'b0;
    force_reset = 1'b1;
    step(3);
    force_reset = 1'b0;
    check_eq("to_rst_loss", int'(lock_loss_cnt), 0);
    rst = 1'b0;
    step(3);
    check_eq("to_p1_hi", int'(pll_rst), 1);
    step(1);
    check_eq("to_p1_lo", int'(pll_rst), 0);
    step(49);
    check_eq("to_wait1", int'(pll_rst), 0);
    check_eq("to_retry0", int'(retry_cnt), 0);
    step(1);
    check_eq("to_p2_hi", int'(pll_rst), 1);
    check_eq("to_retry1", int'(retry_cnt), exp_cnt(1));
    step(3);
    check_eq("to_p2_hold", int'(pll_rst), 1);
    step(1);
    check_eq("to_p2_lo", int'(pll_rst), 0);
    step(49);
    check_eq("to_no_fail_yet", int'(fail), 0);
    step(1);
    check_eq("to_fail", int'(fail), 1);
    check_eq("to_fail_pll_rst", int'(pll_rst), 1);
    check_eq("to_fail_sys_rst", int'(sys_rst), 1);
    check_eq("to_retry2", int'(retry_cnt), exp_cnt(2));
    step(5);
    check_eq("to_fail_held", int'(fail), 1);
    check_eq("to_fail_pll_held", int'(pll_rst), 1);

    // force_reset out of FAIL restarts a full pulse with retries cleared.
    force_reset = 1'b1;
    step(1);
    force_reset = 1'b0;
    check_eq("fr_fail_clr", int'(fail), 0);
    check_eq("fr_pll_rst", int'(pll_rst), 1);
    check_eq("fr_retry", int'(retry_cnt), 0);
    step(3);
    check_eq("fr_pulse_hi", int'(pll_rst), 1);
    step(1);
    check_eq("fr_pulse_lo", int'(pll_rst), 0);

    // One timeout, then a one-cycle lock glitch at STABLE count 5.
    step(49);
    check_eq("gl_wait", int'(pll_rst), 0);
    step(1);
    check_eq("gl_timeout_pulse", int'(pll_rst), 1);
    check_eq("gl_retry1", int'(retry_cnt), exp_cnt(1));
    locked = 1'b1;
    step(10);
    check_eq("gl_in_stable", int'(ready), 0);
    locked = 1'b0;
    step(1);
    locked = 1'b1;
    step(1);
    check_eq("gl_no_run_a", int'(ready), 0);
    step(1);
    check_eq("gl_no_run_b", int'(ready), 0);
    check_eq("gl_pll_rst", int'(pll_rst), 0);
    check_eq("gl_retry_kept", int'(retry_cnt), exp_cnt(1));
    step(8);
    check_eq("gl_not_ready_early", int'(ready), 0);
    step(1);
    check_eq("gl_ready", int'(ready), 1);
    check_eq("gl_retry_clr", int'(retry_cnt), 0);
    check_eq("gl_fail", int'(fail), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pll_96_supervisor.md
PLL_96_SUPERVISOR -- requirements
Module: pll_96_supervisor

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16, giving the PLL reset pulse length in refclk cycles (min 2).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 125000, giving the maximum refclk cycles allowed in WAIT_LOCK (1 ms at 125 MHz).
REQ-003 SHALL have parameter STABLE_CYCLES, default 1024, giving the consecutive locked cycles required before release.
REQ-004 SHALL have parameter MAX_RETRY, default 8, giving the consecutive lock timeouts before FAIL (1..255).
REQ-005 SHALL have port refclk, input, 1 bit: the single clock, the free-running 125 MHz reference, never the PLL output.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port locked, input, 1 bit: the PLL lock indication, asynchronous to refclk.
REQ-008 SHALL have port force_reset, input, 1 bit: a synchronous single-cycle request to restart the sequence.
REQ-009 SHALL have port pll_rst, output, 1 bit: drives the 96 MHz PLL rst.
REQ-010 SHALL have port sys_rst, output, 1 bit: active-high reset for 96 MHz-domain logic, synchronised there by its consumer.
REQ-011 SHALL have port ready, output, 1 bit: high only in RUN.
REQ-012 SHALL have port fail, output, 1 bit: high only in FAIL.
REQ-013 SHALL have port lock_loss_cnt, output, 8 bits: count of RUN-to-loss events, saturating.
REQ-014 SHALL have port retry_cnt, output, 8 bits: consecutive lock timeouts, saturating.

Function
REQ-015 SHALL pass locked through a 2-flop synchroniser to give lock_s; all decisions use lock_s only, so input-to-decision latency is 2 cycles.
REQ-016 SHALL implement states RST_PLL, WAIT_LOCK, STABLE, RUN and FAIL, with all outputs as Moore decodes of the registered state.
REQ-017 SHALL, in RST_PLL: assert pll_rst for exactly RST_CYCLES cycles, then enter WAIT_LOCK with its counter cleared.
REQ-018 SHALL, in WAIT_LOCK: enter STABLE when lock_s=1. If lock_s stays 0 for LOCK_TIMEOUT cycles, increment retry_cnt; if the new value equals MAX_RETRY, enter FAIL, otherwise enter RST_PLL.
REQ-019 SHALL, in STABLE: count cycles while lock_s=1. If lock_s=0, return to WAIT_LOCK with a fresh timeout and no retry increment. On reaching STABLE_CYCLES, enter RUN and clear retry_cnt.
REQ-020 SHALL, in RUN: hold sys_rst=0 and ready=1. If lock_s=0, increment lock_loss_cnt (saturating at 255) and enter RST_PLL.
REQ-021 SHALL, in FAIL: hold pll_rst=1, sys_rst=1 and fail=1 until rst or force_reset.
REQ-022 SHALL drive pll_rst=1 in RST_PLL and FAIL only, and sys_rst=1 in every state except RUN.
REQ-023 SHALL make force_reset move any state to RST_PLL on the next cycle, clearing retry_cnt and the phase counters, with priority over every other transition in the same cycle.
REQ-024 SHALL count lock_loss_cnt as loss when force_reset and a lock_s drop coincide in RUN, and increment it at most once per event.
REQ-025 SHALL size the phase counter as ceil(log2(max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)+1)) bits with no wrap-around.

Reset
REQ-026 SHALL, on a refclk edge with rst=1: set state=RST_PLL, clear the phase counter, synchroniser, lock_loss_cnt and retry_cnt, and drive pll_rst=1, sys_rst=1, ready=0, fail=0.
REQ-027 SHALL let rst asserted mid-sequence override force_reset and restart a full RST_CYCLES pulse after release.

Configuration
REQ-028 SHALL, with macro PLL_96_SUPERVISOR_STATUS_EN defined, implement lock_loss_cnt and the retry_cnt output as specified.
REQ-029 SHALL, without PLL_96_SUPERVISOR_STATUS_EN, drive lock_loss_cnt and retry_cnt outputs as constant 0 while retry limiting and FAIL still work through an internal counter.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=50, STABLE_CYCLES=8, MAX_RETRY=2)
REQ-030 Bench SHALL apply rst for 3 cycles, then hold locked=1 from cycle 10 -> pll_rst high 4 cycles after release, ready=1 exactly 2+8 cycles after lock_s conditions are met, sys_rst=0.
REQ-031 Bench SHALL keep locked=0 throughout -> two 4-cycle pll_rst pulses 50 cycles apart, retry_cnt=1 then 2, fail=1, pll_rst=1 held.
REQ-032 Bench SHALL drop locked for 1 cycle at STABLE count 5 -> back to WAIT_LOCK, retry_cnt unchanged, ready=1 only after 8 further clean cycles.
REQ-033 Bench SHALL drop locked in RUN -> ready=0 and sys_rst=1 within 3 cycles, lock_loss_cnt=1, new 4-cycle pll_rst pulse; repeating 300 times saturates at 255.
REQ-034 Bench SHALL pulse force_reset in FAIL, and again in RUN together with a lock drop -> RST_PLL next cycle, fail=0, retry_cnt=0; lock_loss_cnt +1 for the coincident case.
REQ-035 Bench SHALL rerun REQ-033 without PLL_96_SUPERVISOR_STATUS_EN -> identical pll_rst/sys_rst/ready timing, with counter outputs 0.
